// File: rtl/rx_seq_pkg.sv
// Shared state/cause encodings and default widths for the receive sequencer.
package rx_seq_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int TO_WIDTH_DEF  = 16;
  localparam int SYM_WIDTH     = 15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_HDR      = 3'd2,
    ST_DATA     = 3'd3,
    ST_FCS_WAIT = 3'd4,
    ST_RST      = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_SYNC_TO = 2'd1,
    CAUSE_HDR_BAD = 2'd2,
    CAUSE_DATA_TO = 2'd3
  } abort_cause_t;

  // States in which the stall timer advances on sample strobes.
  function automatic logic is_timed(input seq_state_t s);
    return (s == ST_SYNC) || (s == ST_HDR) || (s == ST_DATA) || (s == ST_FCS_WAIT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/rx_core_sequencer.sv
// Packet-level sequencer for the OFDM receive core: tracks each reception,
// aborts stalled/unsupported ones with a core reset pulse, keeps statistics.
module rx_core_sequencer
  import rx_seq_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int TO_WIDTH  = TO_WIDTH_DEF
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 cfg_enable,
  input  logic                 cfg_clr_cnt,
  input  logic [TO_WIDTH-1:0]  cfg_timeout_th,
  input  logic [3:0]           cfg_rst_len,
  input  logic                 sample_in_strobe,
  input  logic                 short_preamble_detected,
  input  logic                 long_preamble_detected,
  input  logic                 pkt_header_valid_strobe,
  input  logic                 pkt_header_valid,
  input  logic                 ht_unsupport,
  input  logic [14:0]          n_ofdm_sym,
  input  logic                 phy_len_valid,
  input  logic                 ofdm_symbol_eq_out_pulse,
  input  logic                 fcs_out_strobe,
  input  logic                 fcs_ok,
  output logic                 core_rst,
  output logic                 rx_busy,
  output logic [2:0]           seq_state,
  output logic [1:0]           last_abort_cause,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] fcs_err_cnt,
  output logic [CNT_WIDTH-1:0] abort_cnt
);

  seq_state_t              state, state_nxt;
  abort_cause_t            cause_nxt, cause_q;
  logic                    abort_go, pkt_inc, err_inc;
  logic [TO_WIDTH-1:0]     to_cnt, th_m1;
  logic                    timeout_hit, in_pkt, sym_exit;
  logic [SYM_WIDTH-1:0]    sym_cnt, len_q;
  logic                    len_valid;
  logic [3:0]              rst_cnt;

  assign th_m1       = cfg_timeout_th - TO_WIDTH'(1);
  assign timeout_hit = (cfg_timeout_th != '0) && sample_in_strobe && (to_cnt == th_m1);
  assign in_pkt      = (state == ST_DATA) || (state == ST_FCS_WAIT);
  // Without a latched length the data phase only ends on FCS or timeout.
  assign sym_exit    = len_valid && (sym_cnt == len_q);

  // Transition decision, ordered by event priority.
  always_comb begin
    state_nxt = state;
    abort_go  = 1'b0;
    cause_nxt = CAUSE_NONE;
    pkt_inc   = 1'b0;
    err_inc   = 1'b0;
    if (state == ST_RST) begin
      if (rst_cnt == 4'd0) state_nxt = ST_IDLE;
    end else if (!cfg_enable) begin
      state_nxt = ST_IDLE;
    end else if (in_pkt && fcs_out_strobe) begin
      state_nxt = ST_IDLE;
      pkt_inc   = 1'b1;
      err_inc   = ~fcs_ok;
    end else begin
      case (state)
        ST_IDLE: begin
          if (short_preamble_detected) state_nxt = ST_SYNC;
        end
        ST_SYNC: begin
          if (long_preamble_detected) begin
            state_nxt = ST_HDR;
          end else if (timeout_hit) begin
            abort_go  = 1'b1;
            cause_nxt = CAUSE_SYNC_TO;
          end
        end
        ST_HDR: begin
          if (pkt_header_valid_strobe) begin
            if (pkt_header_valid && !ht_unsupport) begin
              state_nxt = ST_DATA;
            end else begin
              abort_go  = 1'b1;
              cause_nxt = CAUSE_HDR_BAD;
            end
          end else if (timeout_hit) begin
            abort_go  = 1'b1;
            cause_nxt = CAUSE_SYNC_TO;
          end
        end
        ST_DATA: begin
          if (sym_exit) begin
            state_nxt = ST_FCS_WAIT;
          end else if (timeout_hit) begin
            abort_go  = 1'b1;
            cause_nxt = CAUSE_DATA_TO;
          end
        end
        ST_FCS_WAIT: begin
          if (timeout_hit) begin
            abort_go  = 1'b1;
            cause_nxt = CAUSE_DATA_TO;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (abort_go) state_nxt = ST_RST;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state     <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      to_cnt    <= '0;
      sym_cnt   <= '0;
      len_q     <= '0;
      len_valid <= 1'b0;
      rst_cnt   <= '0;
      core_rst  <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      core_rst <= (state_nxt == ST_RST);
      rx_busy  <= (state_nxt != ST_IDLE);

      if (state_nxt != state) begin
        to_cnt <= '0;
      end else if ((state == ST_DATA) && ofdm_symbol_eq_out_pulse) begin
        to_cnt <= '0;
      end else if (is_timed(state) && sample_in_strobe) begin
        to_cnt <= to_cnt + TO_WIDTH'(1);
      end

      // A length from a previous packet must never end the next one early.
      if (state == ST_IDLE) begin
        len_valid <= 1'b0;
      end else if (((state == ST_HDR) || (state == ST_DATA)) && phy_len_valid) begin
        len_q     <= n_ofdm_sym;
        len_valid <= 1'b1;
      end

      if ((state == ST_HDR) && (state_nxt == ST_DATA)) begin
        sym_cnt <= '0;
      end else if ((state == ST_DATA) && ofdm_symbol_eq_out_pulse) begin
        sym_cnt <= sym_cnt + SYM_WIDTH'(1);
      end

      if (abort_go) begin
        rst_cnt <= cfg_rst_len;
        cause_q <= cause_nxt;
      end else if ((state == ST_RST) && (rst_cnt != 4'd0)) begin
        rst_cnt <= rst_cnt - 4'd1;
      end
    end
  end

  assign seq_state        = state;
  assign last_abort_cause = cause_q;

  sat_counter #(.W(CNT_WIDTH)) u_pkt_cnt (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .clr   (cfg_clr_cnt),
    .inc   (pkt_inc),
    .cnt   (pkt_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_fcs_err_cnt (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .clr   (cfg_clr_cnt),
    .inc   (err_inc),
    .cnt   (fcs_err_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_abort_cnt (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .clr   (cfg_clr_cnt),
    .inc   (abort_go),
    .cnt   (abort_cnt)
  );

endmodule

// File: tb/tb_rx_core_sequencer.sv
// Directed bench for rx_core_sequencer: a per-cycle vector table plus
// hand-written timeout, saturation and async-reset sequences.
module tb_rx_core_sequencer;

  logic        clk, rst_n;
  logic        cfg_enable, cfg_clr_cnt;
  logic [15:0] cfg_timeout_th;
  logic [3:0]  cfg_rst_len;
  logic        sample_in_strobe, short_preamble_detected, long_preamble_detected;
  logic        pkt_header_valid_strobe, pkt_header_valid, ht_unsupport;
  logic [14:0] n_ofdm_sym;
  logic        phy_len_valid, ofdm_symbol_eq_out_pulse, fcs_out_strobe, fcs_ok;

  logic        core_rst, rx_busy;
  logic [2:0]  seq_state;
  logic [1:0]  last_abort_cause;
  logic [15:0] pkt_cnt, fcs_err_cnt, abort_cnt;

  logic        s_core_rst, s_rx_busy;
  logic [2:0]  s_seq_state;
  logic [1:0]  s_last_abort_cause;
  logic [3:0]  s_pkt_cnt, s_fcs_err_cnt, s_abort_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rx_core_sequencer #(.CNT_WIDTH(16), .TO_WIDTH(16)) dut (
    .s00_axi_aclk             (clk),
    .s00_axi_aresetn          (rst_n),
    .cfg_enable               (cfg_enable),
    .cfg_clr_cnt              (cfg_clr_cnt),
    .cfg_timeout_th           (cfg_timeout_th),
    .cfg_rst_len              (cfg_rst_len),
    .sample_in_strobe         (sample_in_strobe),
    .short_preamble_detected  (short_preamble_detected),
    .long_preamble_detected   (long_preamble_detected),
    .pkt_header_valid_strobe  (pkt_header_valid_strobe),
    .pkt_header_valid         (pkt_header_valid),
    .ht_unsupport             (ht_unsupport),
    .n_ofdm_sym               (n_ofdm_sym),
    .phy_len_valid            (phy_len_valid),
    .ofdm_symbol_eq_out_pulse (ofdm_symbol_eq_out_pulse),
    .fcs_out_strobe           (fcs_out_strobe),
    .fcs_ok                   (fcs_ok),
    .core_rst                 (core_rst),
    .rx_busy                  (rx_busy),
    .seq_state                (seq_state),
    .last_abort_cause         (last_abort_cause),
    .pkt_cnt                  (pkt_cnt),
    .fcs_err_cnt              (fcs_err_cnt),
    .abort_cnt                (abort_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  rx_core_sequencer #(.CNT_WIDTH(4), .TO_WIDTH(16)) dut_small (
    .s00_axi_aclk             (clk),
    .s00_axi_aresetn          (rst_n),
    .cfg_enable               (cfg_enable),
    .cfg_clr_cnt              (cfg_clr_cnt),
    .cfg_timeout_th           (cfg_timeout_th),
    .cfg_rst_len              (cfg_rst_len),
    .sample_in_strobe         (sample_in_strobe),
    .short_preamble_detected  (short_preamble_detected),
    .long_preamble_detected   (long_preamble_detected),
    .pkt_header_valid_strobe  (pkt_header_valid_strobe),
    .pkt_header_valid         (pkt_header_valid),
    .ht_unsupport             (ht_unsupport),
    .n_ofdm_sym               (n_ofdm_sym),
    .phy_len_valid            (phy_len_valid),
    .ofdm_symbol_eq_out_pulse (ofdm_symbol_eq_out_pulse),
    .fcs_out_strobe           (fcs_out_strobe),
    .fcs_ok                   (fcs_ok),
    .core_rst                 (s_core_rst),
    .rx_busy                  (s_rx_busy),
    .seq_state                (s_seq_state),
    .last_abort_cause         (s_last_abort_cause),
    .pkt_cnt                  (s_pkt_cnt),
    .fcs_err_cnt              (s_fcs_err_cnt),
    .abort_cnt                (s_abort_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en, sp, lp, hs, hv, hu, lv;
    logic [14:0] ns;
    logic        sym, fs, fo;
    logic [2:0]  st;
    logic        crst;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] exp_q[$];

  function automatic vec_t mk_vec(input logic en, sp, lp, hs, hv, hu, lv,
                                  input logic [14:0] ns,
                                  input logic sym, fs, fo,
                                  input logic [2:0] st, input logic crst);
    vec_t r;
    r.en = en; r.sp = sp; r.lp = lp; r.hs = hs; r.hv = hv; r.hu = hu; r.lv = lv;
    r.ns = ns; r.sym = sym; r.fs = fs; r.fo = fo; r.st = st; r.crst = crst;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    cfg_enable = 1'b1; cfg_clr_cnt = 1'b0;
    sample_in_strobe = 1'b0; short_preamble_detected = 1'b0; long_preamble_detected = 1'b0;
    pkt_header_valid_strobe = 1'b0; pkt_header_valid = 1'b0; ht_unsupport = 1'b0;
    n_ofdm_sym = '0; phy_len_valid = 1'b0; ofdm_symbol_eq_out_pulse = 1'b0;
    fcs_out_strobe = 1'b0; fcs_ok = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    cfg_enable = v.en; short_preamble_detected = v.sp; long_preamble_detected = v.lp;
    pkt_header_valid_strobe = v.hs; pkt_header_valid = v.hv; ht_unsupport = v.hu;
    phy_len_valid = v.lv; n_ofdm_sym = v.ns; ofdm_symbol_eq_out_pulse = v.sym;
    fcs_out_strobe = v.fs; fcs_ok = v.fo;
    sample_in_strobe = 1'b0; cfg_clr_cnt = 1'b0;
  endtask

  // short, long, good header (optionally with a latched length), leaves core in DATA
  task automatic start_pkt(input logic lv, input logic [14:0] ns);
    clear_inputs(); short_preamble_detected = 1'b1; tick();
    clear_inputs(); long_preamble_detected = 1'b1; tick();
    clear_inputs(); pkt_header_valid_strobe = 1'b1; pkt_header_valid = 1'b1;
    phy_len_valid = lv; n_ofdm_sym = ns; tick();
    clear_inputs();
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      sample_in_strobe = 1'b1; tick();
    end
    sample_in_strobe = 1'b0;
  endtask

  initial begin
    int cnt;
    int guard;
    int hi_seen;

    clear_inputs();
    cfg_timeout_th = 16'd0;
    cfg_rst_len    = 4'd0;
    rst_n = 1'b0;
    #1;
    chk("reset_state", seq_state, 0);
    chk("reset_core_rst", core_rst, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_cause", last_abort_cause, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);
    chk("reset_err_cnt", fcs_err_cnt, 0);
    chk("reset_abort_cnt", abort_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_state", seq_state, 0);

    // en sp lp hs hv hu lv ns sym fs fo -> state core_rst
    // Full packet, length 4
    vecs.push_back(mk_vec(1,1,0,0,0,0,0, 0, 0,0,0, 1,0));
    vecs.push_back(mk_vec(1,0,1,0,0,0,0, 0, 0,0,0, 2,0));
    vecs.push_back(mk_vec(1,0,0,1,1,0,1, 4, 0,0,0, 3,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 1,0,0, 3,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 1,0,0, 3,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 1,0,0, 3,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 1,0,0, 3,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 0,0,0, 4,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 0,1,1, 0,0));
    // Unsupported header -> one-cycle RST (rst_len 0)
    vecs.push_back(mk_vec(1,1,0,0,0,0,0, 0, 0,0,0, 1,0));
    vecs.push_back(mk_vec(1,0,1,0,0,0,0, 0, 0,0,0, 2,0));
    vecs.push_back(mk_vec(1,0,0,1,1,1,0, 0, 0,0,0, 5,1));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 0,0,0, 0,0));
    // Length 0 -> FCS_WAIT next cycle, FCS error
    vecs.push_back(mk_vec(1,1,0,0,0,0,0, 0, 0,0,0, 1,0));
    vecs.push_back(mk_vec(1,0,1,0,0,0,0, 0, 0,0,0, 2,0));
    vecs.push_back(mk_vec(1,0,0,1,1,0,1, 0, 0,0,0, 3,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 0,0,0, 4,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 0,1,0, 0,0));
    // No latched length: symbols never end DATA, FCS does
    vecs.push_back(mk_vec(1,1,0,0,0,0,0, 0, 0,0,0, 1,0));
    vecs.push_back(mk_vec(1,0,1,0,0,0,0, 0, 0,0,0, 2,0));
    vecs.push_back(mk_vec(1,0,0,1,1,0,0, 0, 0,0,0, 3,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 1,0,0, 3,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 1,0,0, 3,0));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 0,1,1, 0,0));
    // Disable forces IDLE and blocks new sync
    vecs.push_back(mk_vec(1,1,0,0,0,0,0, 0, 0,0,0, 1,0));
    vecs.push_back(mk_vec(0,0,1,0,0,0,0, 0, 0,0,0, 0,0));
    vecs.push_back(mk_vec(0,1,0,0,0,0,0, 0, 0,0,0, 0,0));
    // Invalid header -> RST
    vecs.push_back(mk_vec(1,1,0,0,0,0,0, 0, 0,0,0, 1,0));
    vecs.push_back(mk_vec(1,0,1,0,0,0,0, 0, 0,0,0, 2,0));
    vecs.push_back(mk_vec(1,0,0,1,0,0,0, 0, 0,0,0, 5,1));
    vecs.push_back(mk_vec(1,0,0,0,0,0,0, 0, 0,0,0, 0,0));

    foreach (vecs[i]) exp_q.push_back(vecs[i].st);
    foreach (vecs[i]) begin
      logic [2:0] e;
      apply_vec(vecs[i]);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_state", i), seq_state, e);
      chk($sformatf("vec%0d_core_rst", i), core_rst, vecs[i].crst);
      chk($sformatf("vec%0d_busy", i), rx_busy, (e != 3'd0));
    end
    clear_inputs();
    chk("table_pkt_cnt", pkt_cnt, 3);
    chk("table_err_cnt", fcs_err_cnt, 1);
    chk("table_abort_cnt", abort_cnt, 2);
    chk("table_cause", last_abort_cause, 2);

    // Sync timeout after exactly 100 strobes, 8-cycle core reset
    cfg_clr_cnt = 1'b1; tick(); clear_inputs();
    chk("clr_abort_cnt", abort_cnt, 0);
    cfg_timeout_th = 16'd100; cfg_rst_len = 4'd7;
    short_preamble_detected = 1'b1; tick(); clear_inputs();
    strobes(99);
    chk("sync_99_strobes_state", seq_state, 1);
    strobes(1);
    chk("sync_to_state", seq_state, 5);
    chk("sync_to_core_rst", core_rst, 1);
    chk("sync_to_cause", last_abort_cause, 1);
    chk("sync_to_abort_cnt", abort_cnt, 1);
    cnt = 1; guard = 0;
    while (core_rst && guard < 40) begin
      tick(); guard++;
      if (core_rst) cnt++;
    end
    chk("sync_to_rst_len", cnt, 8);
    chk("sync_to_after_state", seq_state, 0);

    // Data stall: 2 of 10 symbols, then silence
    cfg_timeout_th = 16'd50; cfg_rst_len = 4'd1;
    start_pkt(1'b1, 15'd10);
    chk("stall_in_data", seq_state, 3);
    ofdm_symbol_eq_out_pulse = 1'b1; tick(); tick(); clear_inputs();
    strobes(49);
    chk("stall_49_state", seq_state, 3);
    strobes(1);
    chk("stall_to_state", seq_state, 5);
    chk("stall_to_cause", last_abort_cause, 3);
    chk("stall_to_abort_cnt", abort_cnt, 2);
    tick(); tick();
    chk("stall_after_state", seq_state, 0);

    // FCS strobe coincident with the timeout is a packet, not an abort
    start_pkt(1'b1, 15'd10);
    ofdm_symbol_eq_out_pulse = 1'b1; tick(); tick(); clear_inputs();
    strobes(49);
    sample_in_strobe = 1'b1; fcs_out_strobe = 1'b1; fcs_ok = 1'b1; tick(); clear_inputs();
    chk("fcs_vs_to_state", seq_state, 0);
    chk("fcs_vs_to_core_rst", core_rst, 0);
    chk("fcs_vs_to_pkt_cnt", pkt_cnt, 1);
    chk("fcs_vs_to_abort_cnt", abort_cnt, 2);
    chk("fcs_vs_to_cause", last_abort_cause, 3);

    // Saturation on the narrow copy, clear beats increment
    cfg_timeout_th = 16'd0; cfg_rst_len = 4'd0;
    cfg_clr_cnt = 1'b1; tick(); clear_inputs();
    chk("clr_keeps_cause", last_abort_cause, 3);
    for (int p = 0; p < 20; p++) begin
      start_pkt(1'b0, 15'd0);
      fcs_out_strobe = 1'b1; fcs_ok = 1'b0; tick(); clear_inputs();
    end
    chk("sat_pkt_cnt", pkt_cnt, 20);
    chk("sat_err_cnt", fcs_err_cnt, 20);
    chk("sat_small_pkt", s_pkt_cnt, 15);
    chk("sat_small_err", s_fcs_err_cnt, 15);
    start_pkt(1'b0, 15'd0);
    fcs_out_strobe = 1'b1; fcs_ok = 1'b0; cfg_clr_cnt = 1'b1; tick(); clear_inputs();
    chk("clr_inc_pkt_cnt", pkt_cnt, 0);
    chk("clr_inc_err_cnt", fcs_err_cnt, 0);
    chk("clr_inc_small_pkt", s_pkt_cnt, 0);
    start_pkt(1'b0, 15'd0);
    fcs_out_strobe = 1'b1; fcs_ok = 1'b1; tick(); clear_inputs();
    chk("after_clr_pkt_cnt", pkt_cnt, 1);
    chk("after_clr_err_cnt", fcs_err_cnt, 0);

    // Async reset in the middle of a long core reset
    cfg_rst_len = 4'd15;
    clear_inputs(); short_preamble_detected = 1'b1; tick();
    clear_inputs(); long_preamble_detected = 1'b1; tick();
    clear_inputs(); pkt_header_valid_strobe = 1'b1; pkt_header_valid = 1'b1; ht_unsupport = 1'b1; tick();
    clear_inputs();
    chk("arst_pre_state", seq_state, 5);
    tick(); tick();
    chk("arst_mid_core_rst", core_rst, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_core_rst_drop", core_rst, 0);
    chk("arst_state", seq_state, 0);
    tick();
    rst_n = 1'b1;
    hi_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_rst || (seq_state != 3'd0)) hi_seen++;
    end
    chk("arst_no_resume", hi_seen, 0);
    chk("arst_abort_cnt", abort_cnt, 0);
    chk("arst_cause", last_abort_cause, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_core_sequencer.md
# rx_core_sequencer

Packet-level sequencer for the OFDM receive core. It tracks each reception from short-preamble detection through FCS, and aborts a stalled or unsupported reception by pulsing a reset into the core. It also keeps saturating packet, FCS-error and abort counters for AXI-lite status registers. It sits beside the `dot11` instance in the `openofdm_rx` top level; its `core_rst` is ORed into the core reset alongside the existing soft-reset bit and the signal-watchdog reset.

## Interface
- `CNT_WIDTH`, 16, width of each statistics counter
- `TO_WIDTH`, 16, width of the sample-based timeout counter and thresholds
- `s00_axi_aclk`  in  1  single clock
- `s00_axi_aresetn`  in  1  asynchronous, active-low reset
- `cfg_enable`  in  1  0 forces IDLE; no aborts issued
- `cfg_clr_cnt`  in  1  synchronous clear of all statistics counters
- `cfg_timeout_th`  in  TO_WIDTH  stall limit in sample strobes; 0 disables timeouts
- `cfg_rst_len`  in  4  `core_rst` pulse length minus one
- `sample_in_strobe`  in  1  one per baseband sample
- `short_preamble_detected`, `long_preamble_detected`  in  1 each  sync events from the core
- `pkt_header_valid_strobe`, `pkt_header_valid`, `ht_unsupport`  in  1 each  header result
- `n_ofdm_sym`  in  15  data symbols in the packet
- `phy_len_valid`  in  1  qualifies `n_ofdm_sym`
- `ofdm_symbol_eq_out_pulse`  in  1  one per equalized symbol
- `fcs_out_strobe`, `fcs_ok`  in  1 each  end of packet
- `core_rst`  out  1  reset pulse to the core
- `rx_busy`  out  1  state ≠ IDLE
- `seq_state`  out  3  current state code
- `last_abort_cause`  out  2  0 none, 1 sync/header timeout, 2 header bad or unsupported, 3 data/FCS timeout
- `pkt_cnt`, `fcs_err_cnt`, `abort_cnt`  out  CNT_WIDTH each  statistics

## Operation
- States and codes: IDLE 0, SYNC 1, HDR 2, DATA 3, FCS_WAIT 4, RST 5.
- **Timeout counter (`to_cnt`)**
  - Clears on every state entry; in DATA it also clears on each `ofdm_symbol_eq_out_pulse`.
  - Otherwise increments on `sample_in_strobe`.
  - Timeout fires when `to_cnt == cfg_timeout_th-1` and a strobe arrives, with `cfg_timeout_th ≠ 0`.
- **IDLE**: `short_preamble_detected` → SYNC.
- **SYNC**
  - `long_preamble_detected` → HDR.
  - Timeout → RST with cause 1.
- **HDR**
  - `pkt_header_valid_strobe & pkt_header_valid & ~ht_unsupport` → DATA, clearing `sym_cnt`.
  - A header strobe with any other combination → RST with cause 2.
  - Timeout → RST with cause 1.
- **Symbol length latch**: `n_ofdm_sym` is latched whenever `phy_len_valid` is high in HDR or DATA. If no valid length has been latched, the symbol-count exit is disabled.
- **DATA**
  - Each `ofdm_symbol_eq_out_pulse` increments `sym_cnt` (15 bits).
  - When `sym_cnt` reaches the latched length → FCS_WAIT. A latched length of 0 gives FCS_WAIT on the next cycle.
  - Timeout → RST with cause 3.
- **FCS_WAIT**: timeout → RST with cause 3.
- **FCS strobe** (in DATA or FCS_WAIT): `fcs_out_strobe` → IDLE; `pkt_cnt`+1; `fcs_err_cnt`+1 if `~fcs_ok`.
- **RST**
  - `core_rst`=1 while here.
  - A down-counter is loaded with `cfg_rst_len` on entry; exit to IDLE when it reaches 0.
  - All other inputs are ignored.
  - `abort_cnt`+1 and `last_abort_cause` are updated on entry.
- **Counters**: saturate at all-ones. `cfg_clr_cnt` beats a simultaneous increment. `last_abort_cause` is not cleared by `cfg_clr_cnt`.
- **`cfg_enable`=0**
  - Next state is IDLE from any state except RST; an in-progress RST completes.
  - No counters increment.

## Timing
- **Reset values**: all outputs 0; state IDLE; latched length invalid.
- **Registered outputs**: every output is registered and reflects the state one cycle after the causing input edge.
- **`core_rst` pulse**: high exactly `cfg_rst_len+1` consecutive cycles, beginning the cycle `seq_state` first reads 5.
- **Simultaneous-event priority** (highest first): `cfg_enable`=0, `fcs_out_strobe`, header strobe, symbol-count exit, preamble events, timeout. An FCS strobe coincident with a timeout is counted as a packet, not an abort.
- **Async reset mid-RST**: `core_rst` drops asynchronously; no pulse resumes after reset release.

## Structure
- **Package `rx_seq_pkg`**:
  - state codes, abort cause codes
  - default widths
- **Sub-module `sat_counter`**: parameterized width, inc/clr inputs, clear priority. Instantiated three times.

## Test plan
- Full packet: short, long, valid header, `n_ofdm_sym`=4, four symbol pulses, `fcs_ok`=1 → states 1,2,3,4,0; `pkt_cnt`=1; `core_rst` never high.
- `cfg_timeout_th`=100, short preamble with no long preamble → RST after exactly 100 strobes; `core_rst` high 8 cycles with `cfg_rst_len`=7; cause 1; `abort_cnt`=1.
- Header strobe with `ht_unsupport`=1 → RST next cycle, cause 2.
- Data stall: 2 of 10 symbols then silence with `cfg_timeout_th`=50 → cause 3. `fcs_out_strobe` on the timeout cycle → IDLE, `pkt_cnt`+1, `abort_cnt` unchanged.
- `fcs_ok`=0 → `fcs_err_cnt`=1. Preload to 0xFFFF → holds at 0xFFFF. `cfg_clr_cnt` together with an increment → 0.
- `s00_axi_aresetn` low during RST → `core_rst` 0 immediately; IDLE after release.
